// File: rtl/music_sequencer.sv
// music_sequencer: plays an external note table as a square wave with start/stop/pause, loop and song length.
// Optional MUSIC_OCTAVE_EN: latched half-period is note >> octave; otherwise octave is ignored.
module music_sequencer #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 8,
    parameter int ADDR_W  = 10,
    parameter int NOTE_W  = 20,
    parameter int DUR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop,
    input  logic [ADDR_W-1:0] song_len,
    input  logic [NOTE_W-1:0] note,
    input  logic [DUR_W-1:0]  duration,
    input  logic [1:0]        octave,
    output logic [ADDR_W-1:0] addr,
    output logic              audio,
    output logic              playing,
    output logic              done
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [DUR_W:0]    step_q, step_d;
    logic [NOTE_W-1:0] tone_q, tone_d;
    logic              audio_q, audio_d;
    logic              done_q, done_d;

    logic [NOTE_W-1:0] eff_note;
    logic [DUR_W:0]    dur_eff;
    logic [ADDR_W:0]   addr_nx;
    logic              tick_wrap, tone_wrap, step_end, more;

`ifdef MUSIC_OCTAVE_EN
    assign eff_note = note >> octave;
`else
    logic unused_octave;
    assign unused_octave = ^octave;
    assign eff_note = note;
`endif

    assign dur_eff   = (dur_q == '0) ? (DUR_W+1)'(1) : {1'b0, dur_q};
    assign tick_wrap = tick_q == TW'(TICK_DIV - 1);
    assign tone_wrap = tone_q == note_q - NOTE_W'(1);
    assign step_end  = tick_wrap && (step_q + (DUR_W+1)'(1) == dur_eff);
    assign addr_nx   = {1'b0, addr_q} + (ADDR_W+1)'(1);
    assign more      = addr_nx < {1'b0, song_len};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        note_d  = note_q;
        dur_d   = dur_q;
        tick_d  = tick_q;
        step_d  = step_q;
        tone_d  = tone_q;
        audio_d = audio_q;
        done_d  = 1'b0;
        if (stop) begin
            state_d = IDLE;
            addr_d  = '0;
            audio_d = 1'b0;
            tick_d  = '0;
            step_d  = '0;
            tone_d  = '0;
        end else if (pause) begin
            done_d = 1'b0;
        end else if (start) begin
            addr_d  = '0;
            audio_d = 1'b0;
            tick_d  = '0;
            step_d  = '0;
            tone_d  = '0;
            state_d = (song_len != '0) ? FETCH : IDLE;
            done_d  = (song_len == '0);
        end else begin
            unique case (state_q)
                FETCH: begin
                    note_d  = eff_note;
                    dur_d   = duration;
                    tick_d  = '0;
                    step_d  = '0;
                    tone_d  = '0;
                    audio_d = 1'b0;
                    state_d = PLAY;
                end
                PLAY: begin
                    tick_d = tick_wrap ? '0 : tick_q + TW'(1);
                    step_d = tick_wrap ? step_q + (DUR_W+1)'(1) : step_q;
                    // Codes below 2 are rests: the tone counter stays idle and audio stays low.
                    if (note_q >= NOTE_W'(2)) begin
                        tone_d  = tone_wrap ? '0 : tone_q + NOTE_W'(1);
                        audio_d = audio_q ^ tone_wrap;
                    end
                    if (step_end) begin
                        audio_d = 1'b0;
                        addr_d  = more ? addr_nx[ADDR_W-1:0] : '0;
                        state_d = (more || loop) ? FETCH : IDLE;
                        done_d  = !more && !loop;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            note_q  <= '0;
            dur_q   <= '0;
            tick_q  <= '0;
            step_q  <= '0;
            tone_q  <= '0;
            audio_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            tick_q  <= tick_d;
            step_q  <= step_d;
            tone_q  <= tone_d;
            audio_q <= audio_d;
            done_q  <= done_d;
        end
    end

    assign addr    = addr_q;
    assign audio   = audio_q && !pause;
    assign playing = state_q != IDLE;
    assign done    = done_q;
endmodule

// File: tb/tb_music_sequencer.sv
// tb_music_sequencer: directed checks of the note player with TICK_DIV = 10 and a small table model.
module tb_music_sequencer;
    logic        clk = 1'b0;
    logic        rst, start, stop, pause, loop;
    logic [9:0]  song_len, addr;
    logic [19:0] note;
    logic [4:0]  duration;
    logic [1:0]  octave;
    logic        audio, playing, done;
    logic [19:0] rom_note [4];
    logic [4:0]  rom_dur  [4];
    int checks = 0, errors = 0, done_cnt = 0, hp, d0;

    music_sequencer #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .loop(loop),
        .song_len(song_len), .note(note), .duration(duration), .octave(octave),
        .addr(addr), .audio(audio), .playing(playing), .done(done)
    );

    always #5 clk = ~clk;

    always_comb begin
        note     = rom_note[addr[1:0]];
        duration = rom_dur[addr[1:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (done) done_cnt++;
    endtask

    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; loop = 1'b0;
        song_len = 10'd2; octave = 2'd0;
        rom_note[0] = 20'd4; rom_dur[0] = 5'd2;
        rom_note[1] = 20'd1; rom_dur[1] = 5'd1;
        rom_note[2] = 20'd0; rom_dur[2] = 5'd0;
        rom_note[3] = 20'd0; rom_dur[3] = 5'd0;
        repeat (3) step();
        rst = 1'b0;
        check("rst_addr", addr, 0);
        check("rst_audio", audio, 0);
        check("rst_playing", playing, 0);
        check("rst_done", done, 0);

        // Two-entry song, no loop
        go();
        check("t2_fetch_playing", playing, 1);
        check("t2_fetch_addr", addr, 0);
        check("t2_fetch_audio", audio, 0);
        for (int k = 0; k < 20; k++) begin
            step();
            check($sformatf("t2_tone_c%0d", k), audio, (k / 4) % 2);
        end
        step();
        check("t2_fetch1_addr", addr, 1);
        check("t2_fetch1_audio", audio, 0);
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("t2_rest_c%0d", k), {addr[3:0], audio}, {4'd1, 1'b0});
        end
        step();
        check("t2_done", done, 1);
        check("t2_idle_playing", playing, 0);
        check("t2_idle_addr", addr, 0);
        step();
        check("t2_done_pulse", done, 0);

        // Looping: 32-cycle period, no done
        loop = 1'b1;
        d0 = done_cnt;
        go();
        for (int it = 0; it < 3; it++) begin
            check($sformatf("t3_fetch0_it%0d", it), {playing, addr[3:0], audio}, {1'b1, 4'd0, 1'b0});
            repeat (21) step();
            check($sformatf("t3_fetch1_it%0d", it), addr, 1);
            repeat (11) step();
        end
        check("t3_no_done", done_cnt - d0, 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t5_stop_playing", playing, 0);
        check("t5_stop_addr", addr, 0);
        check("t5_stop_audio", audio, 0);
        step();
        check("t5_stop_no_done", done_cnt - d0, 0);

        // Pause 7 cycles in the middle of the first step
        loop = 1'b0;
        go();
        repeat (6) step();
        check("t4_pre_audio", audio, 1);
        pause = 1'b1;
        #1;
        check("t4_pause_audio", audio, 0);
        for (int k = 0; k < 7; k++) begin
            step();
            check($sformatf("t4_frozen_%0d", k), {playing, addr[3:0], audio}, {1'b1, 4'd0, 1'b0});
        end
        pause = 1'b0;
        #1;
        check("t4_resume_audio", audio, 1);
        repeat (14) step();
        check("t4_last_cycle_addr", addr, 0);
        step();
        check("t4_delayed_fetch_addr", addr, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t4_stop_playing", playing, 0);

        // start ignored while paused
        pause = 1'b1;
        go();
        check("pause_blocks_start", playing, 0);
        pause = 1'b0;

        // Empty song
        song_len = 10'd0;
        d0 = done_cnt;
        go();
        check("t5_empty_done", done, 1);
        check("t5_empty_playing", playing, 0);
        step();
        check("t5_empty_pulse", done, 0);
        check("t5_empty_done_count", done_cnt - d0, 1);

        // Octave shift (or ignored octave in default build)
        rom_note[0] = 20'd8; rom_dur[0] = 5'd1;
        song_len = 10'd1;
        for (int o = 1; o <= 3; o += 2) begin
            octave = 2'(o);
`ifdef MUSIC_OCTAVE_EN
            hp = 8 >> o;
`else
            hp = 8;
`endif
            go();
            for (int k = 0; k < 10; k++) begin
                step();
                check($sformatf("t6_oct%0d_c%0d", o, k), audio, (hp < 2) ? 0 : (k / hp) % 2);
            end
            check($sformatf("t6_oct%0d_end", o), playing, 1);
            step();
            check($sformatf("t6_oct%0d_done", o), done, 1);
        end

        // Reset mid-play
        song_len = 10'd2;
        rom_note[0] = 20'd4; rom_dur[0] = 5'd2;
        go();
        repeat (25) step();
        rst = 1'b1;
        step();
        check("t1_rst_addr", addr, 0);
        check("t1_rst_audio", audio, 0);
        check("t1_rst_playing", playing, 0);
        check("t1_rst_done", done, 0);
        repeat (2) step();
        rst = 1'b0;
        step();
        check("t1_after_rst_playing", playing, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
